stream8x2_axis_arb: RTL and testbench

Packet-level round-robin arbiter that merges two 8-bit AXI4-Stream producers into the single input channel of the `stream8x2` kernel. The arbiter holds its grant for a whole packet (TLAST-delimited), tags each beat with its source ID, and registers the output. A stall watchdog drives the per-channel `axis_block_sigs[1:0]` vector consumed by the kernel's deadlock monitor.

---
 rtl/stream8x2_axis_arb.sv | 154 +++++++++++++++
 tb/tb_stream8x2_axis_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream8x2_axis_arb.sv
// stream8x2_axis_arb: packet-level round-robin merge of two 8-bit AXI4-Stream
// producers into one registered output stream tagged with the source ID.
// A grant is held from the first beat of a packet until its TLAST beat.
// Optional stall watchdog (driving axis_block_sigs) is built only when the
// macro STREAM8X2_ARB_WATCHDOG_EN is defined; otherwise axis_block_sigs is 0.
module stream8x2_axis_arb #(
    parameter int STALL_LIMIT = 256,
    parameter int CNT_W       = 16
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    input  logic       s0_tlast,
    output logic       s0_tready,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    input  logic       s1_tlast,
    output logic       s1_tready,
    output logic [7:0] m_tdata,
    output logic       m_tid,
    output logic       m_tlast,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [1:0] axis_block_sigs,
    output logic       grant_busy
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] m_tdata_q;
    logic       m_tid_q, m_tlast_q, m_tvalid_q, m_tvalid_d;
    logic       load, grant0, grant1;
    logic       accept, acc_last;

    // The output register can take a beat when it is empty or draining now.
    assign load = !m_tvalid_q || m_tready;

    // Pick the granted channel: locked channel, else round-robin among valids.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            LOCK0: grant0 = 1'b1;
            LOCK1: grant1 = 1'b1;
            default: begin
                if (s0_tvalid && (!s1_tvalid || last_q)) begin
                    grant0 = 1'b1;
                end else if (s1_tvalid) begin
                    grant1 = 1'b1;
                end
            end
        endcase
    end

    assign s0_tready = load && grant0;
    assign s1_tready = load && grant1;
    assign accept    = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);
    assign acc_last  = grant1 ? s1_tlast : s0_tlast;

    // Next grant state: a TLAST beat releases the lock and records the server.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (accept) begin
            if (acc_last) begin
                state_d = IDLE;
                last_d  = grant1;
            end else begin
                state_d = grant1 ? LOCK1 : LOCK0;
            end
        end
    end

    // Output valid is set on an accepted beat and cleared once drained.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        if (accept) begin
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // Grant state, last-served pointer and registered output beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 8'h00;
            m_tid_q    <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            m_tvalid_q <= m_tvalid_d;
            if (accept) begin
                m_tdata_q <= grant1 ? s1_tdata : s0_tdata;
                m_tid_q   <= grant1;
                m_tlast_q <= acc_last;
            end
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tid      = m_tid_q;
    assign m_tlast    = m_tlast_q;
    assign m_tvalid   = m_tvalid_q;
    assign grant_busy = (state_q != IDLE);

`ifdef STREAM8X2_ARB_WATCHDOG_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    logic [1:0]       stall;
    logic [1:0]       block_q, block_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    assign stall = {s1_tvalid && !s1_tready, s0_tvalid && !s0_tready};

    // Saturating stall counters; a channel is reported while still stalled at the limit.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]   = '0;
            block_d[i] = 1'b0;
            if (stall[i]) begin
                cnt_d[i]   = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
                block_d[i] = (cnt_q[i] == LIMIT);
            end
        end
    end

    // Watchdog counter and blocked-flag registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            block_q  <= 2'b00;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            block_q  <= block_d;
        end
    end

    assign axis_block_sigs = block_q;
`else
    assign axis_block_sigs = 2'b00;
`endif

endmodule

// File: tb/tb_stream8x2_axis_arb.sv
// Directed scoreboard bench for stream8x2_axis_arb (STALL_LIMIT=4).
module tb_stream8x2_axis_arb;

    localparam int STALL_LIMIT = 4;
`ifdef STREAM8X2_ARB_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s0_tdata, s1_tdata, m_tdata;
    logic       s0_tvalid, s0_tlast, s0_tready;
    logic       s1_tvalid, s1_tlast, s1_tready;
    logic       m_tid, m_tlast, m_tvalid;
    logic       m_tready = 1'b0;
    logic [1:0] axis_block_sigs;
    logic       grant_busy;

    logic [8:0] p0 [$];
    logic [8:0] p1 [$];
    logic [9:0] sb [$];
    int         outCyc [$];
    int         firstAcc;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    stream8x2_axis_arb #(.STALL_LIMIT(STALL_LIMIT), .CNT_W(16)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tid(m_tid), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .axis_block_sigs(axis_block_sigs), .grant_busy(grant_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present the head of each producer queue.
    task automatic drive();
        s0_tvalid = (p0.size() != 0);
        s0_tdata  = (p0.size() != 0) ? p0[0][7:0] : 8'h00;
        s0_tlast  = (p0.size() != 0) ? p0[0][8] : 1'b0;
        s1_tvalid = (p1.size() != 0);
        s1_tdata  = (p1.size() != 0) ? p1[0][7:0] : 8'h00;
        s1_tlast  = (p1.size() != 0) ? p1[0][8] : 1'b0;
    endtask

    // One clock: sample handshakes mid-cycle, score output beats, advance producers.
    task automatic tick();
        logic h0, h1, hm;
        logic [9:0] exp;
        @(negedge clk);
        h0 = s0_tvalid && s0_tready;
        h1 = s1_tvalid && s1_tready;
        hm = m_tvalid && m_tready;
        if (hm) begin
            outCyc.push_back(cyc);
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("beat", {m_tid, m_tlast, m_tdata}, exp);
            end
        end
        if ((h0 || h1) && firstAcc < 0) firstAcc = cyc;
        @(posedge clk);
        #1;
        if (h0) void'(p0.pop_front());
        if (h1) void'(p1.pop_front());
        drive();
        #1;
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while ((p0.size() != 0 || p1.size() != 0 || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(p0.size() == 0 && p1.size() == 0 && sb.size() == 0), 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        p0.delete(); p1.delete(); sb.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic clearTrace();
        outCyc.delete();
        firstAcc = -1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        drive();
        #1 rst_n = 1'b0;
        #1;
        $display("[TB] reset values");
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tid", m_tid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_block", axis_block_sigs, 0);
        chk("rst_busy", grant_busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] single channel back-to-back");
        m_tready = 1'b1;
        clearTrace();
        for (int i = 0; i < 4; i++) begin
            p0.push_back({i == 3, 8'(8'h10 + i)});
            sb.push_back({1'b0, i == 3, 8'(8'h10 + i)});
        end
        drive();
        #1;
        run("t1", 20);
        chk("t1_count", outCyc.size(), 4);
        if (outCyc.size() == 4)
            for (int k = 0; k < 4; k++) chk("t1_cycle", outCyc[k], firstAcc + 1 + k);

        $display("[TB] contention after reset");
        doReset();
        clearTrace();
        p0.push_back({1'b0, 8'hA0}); p0.push_back({1'b1, 8'hA1});
        p1.push_back({1'b0, 8'hB0}); p1.push_back({1'b1, 8'hB1});
        sb.push_back({1'b0, 1'b0, 8'hA0}); sb.push_back({1'b0, 1'b1, 8'hA1});
        sb.push_back({1'b1, 1'b0, 8'hB0}); sb.push_back({1'b1, 1'b1, 8'hB1});
        drive();
        #1;
        chk("t2_s0_ready", s0_tready, 1);
        chk("t2_s1_ready", s1_tready, 0);
        run("t2", 20);
        chk("t2_count", outCyc.size(), 4);
        if (outCyc.size() == 4)
            for (int k = 1; k < 4; k++) chk("t2_no_bubble", outCyc[k], outCyc[0] + k);

        $display("[TB] packet lock");
        clearTrace();
        p0.push_back({1'b0, 8'hC0}); p0.push_back({1'b0, 8'hC1}); p0.push_back({1'b1, 8'hC2});
        sb.push_back({1'b0, 1'b0, 8'hC0}); sb.push_back({1'b0, 1'b0, 8'hC1});
        sb.push_back({1'b0, 1'b1, 8'hC2}); sb.push_back({1'b1, 1'b1, 8'hD0});
        drive();
        #1;
        tick();
        p1.push_back({1'b1, 8'hD0});
        drive();
        #1;
        chk("t3_s1_blocked_b2", s1_tready, 0);
        tick();
        chk("t3_s1_blocked_b3", s1_tready, 0);
        chk("t3_s0_ready_b3", s0_tready, 1);
        tick();
        chk("t3_s1_granted", s1_tready, 1);
        run("t3", 20);

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) begin
            p0.push_back({i == 3, 8'(8'h40 + i)});
            sb.push_back({1'b0, i == 3, 8'(8'h40 + i)});
        end
        drive();
        #1;
        tick();
        tick();
        m_tready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_hold_data", m_tdata, 8'h41);
            chk("t4_hold_valid", m_tvalid, 1);
            chk("t4_s0_stall", s0_tready, 0);
            tick();
        end
        m_tready = 1'b1;
        #1;
        run("t4", 20);

        $display("[TB] watchdog");
        m_tready = 1'b0;
        p1.push_back({1'b0, 8'h50}); p1.push_back({1'b1, 8'h51});
        sb.push_back({1'b1, 1'b0, 8'h50}); sb.push_back({1'b1, 1'b1, 8'h51});
        drive();
        #1;
        chk("t5_first_accept", s1_tready, 1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t5_block1", axis_block_sigs[1], WD && (k >= 6));
            chk("t5_block0", axis_block_sigs[0], 0);
            chk("t5_held", m_tdata, 8'h50);
        end
        m_tready = 1'b1;
        #1;
        chk("t5_accept", s1_tready, 1);
        chk("t5_block_hold", axis_block_sigs[1], WD);
        tick();
        chk("t5_block_fall", axis_block_sigs[1], 0);
        run("t5", 20);

        $display("[TB] reset mid-packet");
        for (int i = 0; i < 4; i++) begin
            p0.push_back({i == 3, 8'(8'h60 + i)});
            sb.push_back({1'b0, i == 3, 8'(8'h60 + i)});
        end
        drive();
        #1;
        tick();
        chk("t6_busy_before", grant_busy, 1);
        chk("t6_valid_before", m_tvalid, 1);
        rst_n = 1'b0;
        p0.delete(); sb.delete();
        drive();
        #1;
        chk("t6_valid_async", m_tvalid, 0);
        chk("t6_busy_async", grant_busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p1.push_back({1'b1, 8'h71});
        p0.push_back({1'b1, 8'h70});
        sb.push_back({1'b0, 1'b1, 8'h70}); sb.push_back({1'b1, 1'b1, 8'h71});
        drive();
        #1;
        chk("t6_s0_first", s0_tready, 1);
        chk("t6_s1_wait", s1_tready, 0);
        run("t6", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
